// File: rtl/decode_token.sv
// decode_token: LZS token parser.
// Reads a 13-bit MSB-aligned bit window from the unpacker and decodes literal,
// short-copy, long-copy and end-marker tokens, including the variable-length
// length field. Reports consumed bits back upstream and emits one registered
// token per code over a valid/ready handshake.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   stream_data[12:0]        bit window, bit 12 = next unconsumed bit
//   stream_valid             window holds enough valid bits to decode
//   stream_done              upstream exhausted (end-marker padding skipped)
//   stream_width[3:0]        bits consumed this cycle, 0 when stream_ack=0
//   stream_ack               consume stream_width bits
//   tok_valid / tok_ready    token handshake
//   tok_type[1:0]            00 literal, 01 copy, 10 end-of-block
//   tok_lit[7:0]             literal byte
//   tok_off[10:0]            copy offset
//   tok_len[LEN_W-1:0]       copy length, saturating
//   tok_err                  sticky length-saturation flag
module decode_token #(
  parameter int unsigned LEN_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [12:0]      stream_data,
  input  logic             stream_valid,
  input  logic             stream_done,
  output logic [3:0]       stream_width,
  output logic             stream_ack,
  output logic             tok_valid,
  input  logic             tok_ready,
  output logic [1:0]       tok_type,
  output logic [7:0]       tok_lit,
  output logic [10:0]      tok_off,
  output logic [LEN_W-1:0] tok_len,
  output logic             tok_err
);

  typedef enum logic [2:0] {S_TAG, S_LEN, S_EXT, S_PAD, S_EMIT} state_t;

  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  state_t           state;
  logic [2:0]       bitcnt;
  logic [10:0]      off_r;
  logic [LEN_W-1:0] len_r;

  logic [2:0]       pad;
  logic [LEN_W:0]   ext_sum;
  logic             ext_ovf;
  logic [LEN_W-1:0] ext_len;

  // Bits needed to reach the next byte boundary: (8 - bitcnt) mod 8.
  assign pad     = 3'd0 - bitcnt;
  assign ext_sum = {1'b0, len_r} + (LEN_W+1)'(stream_data[12:9]);
  assign ext_ovf = ext_sum > {1'b0, LEN_MAX};
  assign ext_len = ext_ovf ? LEN_MAX : ext_sum[LEN_W-1:0];

  always_comb begin
    stream_ack   = 1'b0;
    stream_width = '0;
    case (state)
      S_TAG: if (stream_valid) begin
        stream_ack   = 1'b1;
        stream_width = (stream_data[12:11] == 2'b10) ? 4'd13 : 4'd9;
      end
      S_LEN: if (stream_valid) begin
        stream_ack   = 1'b1;
        stream_width = (stream_data[12:11] == 2'b11) ? 4'd4 : 4'd2;
      end
      S_EXT: if (stream_valid) begin
        stream_ack   = 1'b1;
        stream_width = 4'd4;
      end
      S_PAD: if (stream_valid && pad != 3'd0 && !stream_done) begin
        stream_ack   = 1'b1;
        stream_width = {1'b0, pad};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_TAG;
      bitcnt    <= '0;
      off_r     <= '0;
      len_r     <= '0;
      tok_valid <= 1'b0;
      tok_type  <= '0;
      tok_lit   <= '0;
      tok_off   <= '0;
      tok_len   <= '0;
      tok_err   <= 1'b0;
    end else begin
      if (stream_ack) bitcnt <= bitcnt + stream_width[2:0];
      case (state)
        S_TAG: if (stream_valid) begin
          if (!stream_data[12]) begin
            tok_type  <= 2'b00;
            tok_lit   <= stream_data[11:4];
            tok_valid <= 1'b1;
            state     <= S_EMIT;
          end else if (stream_data[11]) begin
            // A zero 7-bit offset is the end marker, not a copy.
            if (stream_data[10:4] != 7'd0) begin
              off_r <= {4'd0, stream_data[10:4]};
              state <= S_LEN;
            end else begin
              state <= S_PAD;
            end
          end else begin
            off_r <= stream_data[10:0];
            state <= S_LEN;
          end
        end
        S_LEN: if (stream_valid) begin
          if (stream_data[12:11] != 2'b11) begin
            tok_type  <= 2'b01;
            tok_off   <= off_r;
            tok_len   <= LEN_W'(3'd2 + {1'b0, stream_data[12:11]});
            tok_valid <= 1'b1;
            state     <= S_EMIT;
          end else if (stream_data[10:9] != 2'b11) begin
            tok_type  <= 2'b01;
            tok_off   <= off_r;
            tok_len   <= LEN_W'(3'd5 + {1'b0, stream_data[10:9]});
            tok_valid <= 1'b1;
            state     <= S_EMIT;
          end else begin
            len_r <= LEN_W'(4'd8);
            state <= S_EXT;
          end
        end
        S_EXT: if (stream_valid) begin
          len_r <= ext_len;
          if (ext_ovf) tok_err <= 1'b1;
          if (stream_data[12:9] != 4'hF) begin
            tok_type  <= 2'b01;
            tok_off   <= off_r;
            tok_len   <= ext_len;
            tok_valid <= 1'b1;
            state     <= S_EMIT;
          end
        end
        S_PAD: if (pad == 3'd0 || stream_done || stream_valid) begin
          tok_type  <= 2'b10;
          tok_valid <= 1'b1;
          state     <= S_EMIT;
        end
        S_EMIT: if (tok_ready) begin
          tok_valid <= 1'b0;
          state     <= S_TAG;
          if (tok_type == 2'b10) bitcnt <= '0;
        end
        default: state <= S_TAG;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_token.sv
// tb_decode_token: self-checking bench for decode_token.
// A bit-queue upstream model feeds the window; expected ack widths and tokens
// are queued when a code is pushed and compared as the DUT acks / emits.
// A second instance with LEN_W=5 exercises length saturation and reset.
module tb_decode_token;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [12:0] stream_data;
  logic        stream_valid, stream_done;
  logic [3:0]  stream_width;
  logic        stream_ack;
  logic        tok_valid, tok_ready;
  logic [1:0]  tok_type;
  logic [7:0]  tok_lit;
  logic [10:0] tok_off;
  logic [10:0] tok_len;
  logic        tok_err;

  logic [12:0] s5_data;
  logic        s5_valid, s5_done;
  logic [3:0]  s5_width;
  logic        s5_ack;
  logic        s5_tvalid, s5_ready;
  logic [1:0]  s5_type;
  logic [7:0]  s5_lit;
  logic [10:0] s5_off;
  logic [4:0]  s5_len;
  logic        s5_err;

  decode_token #(.LEN_W(11)) dut (
    .clk(clk), .rst(rst), .stream_data(stream_data), .stream_valid(stream_valid),
    .stream_done(stream_done), .stream_width(stream_width), .stream_ack(stream_ack),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_type(tok_type), .tok_lit(tok_lit),
    .tok_off(tok_off), .tok_len(tok_len), .tok_err(tok_err));

  decode_token #(.LEN_W(5)) dut5 (
    .clk(clk), .rst(rst), .stream_data(s5_data), .stream_valid(s5_valid),
    .stream_done(s5_done), .stream_width(s5_width), .stream_ack(s5_ack),
    .tok_valid(s5_tvalid), .tok_ready(s5_ready), .tok_type(s5_type), .tok_lit(s5_lit),
    .tok_off(s5_off), .tok_len(s5_len), .tok_err(s5_err));

  typedef struct {
    logic [1:0]  typ;
    logic [7:0]  lit;
    logic [10:0] off;
    logic [10:0] len;
  } tok_t;

  // w: expected ack widths, one per nibble from the top, 0 = unused
  typedef struct {
    logic [31:0] bits;
    int unsigned nbits;
    logic [1:0]  typ;
    logic [7:0]  lit;
    logic [10:0] off;
    logic [10:0] len;
    logic [23:0] w;
  } vec_t;

  bit          bitq[$];
  logic [3:0]  expw[$];
  tok_t        expt[$];
  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned model_cnt = 0;
  logic        src_en = 1'b0;
  logic        expect_idle = 1'b0;
  vec_t        vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < 13; i++)
      stream_data[12-i] = (i < bitq.size()) ? bitq[i] : 1'b0;
    stream_valid = src_en && (bitq.size() != 0);
  endtask

  task automatic push_bits(input logic [31:0] b, input int unsigned n);
    for (int i = int'(n) - 1; i >= 0; i--) bitq.push_back(b[i]);
    model_cnt += n;
  endtask

  task automatic push_vec(input vec_t v);
    tok_t t;
    logic [3:0] nib;
    push_bits(v.bits, v.nbits);
    for (int k = 5; k >= 0; k--) begin
      nib = v.w[k*4 +: 4];
      if (nib != 4'd0) expw.push_back(nib);
    end
    t.typ = v.typ; t.lit = v.lit; t.off = v.off; t.len = v.len;
    expt.push_back(t);
  endtask

  task automatic push_end(input logic done);
    tok_t t;
    int unsigned pad;
    push_bits(32'h180, 9);
    expw.push_back(4'd9);
    pad = (8 - (model_cnt % 8)) % 8;
    if (!done && pad != 0) begin
      push_bits(32'd0, pad);
      expw.push_back(4'(pad));
    end
    t.typ = 2'b10; t.lit = '0; t.off = '0; t.len = '0;
    expt.push_back(t);
    model_cnt = 0;
  endtask

  task automatic cycle();
    tok_t t;
    @(negedge clk);
    if (expect_idle) begin
      check("valid_drop_after_accept", tok_valid, 0);
      expect_idle = 1'b0;
    end
    if (stream_ack) begin
      if (tok_valid) check("ack_in_emit", stream_ack, 0);
      if (!stream_valid) check("ack_without_valid", stream_ack, 0);
      if (expw.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_ack: width %0d, none expected", stream_width);
      end else begin
        check("ack_width", stream_width, expw.pop_front());
      end
      for (int i = 0; i < int'(stream_width); i++)
        if (bitq.size() != 0) void'(bitq.pop_front());
    end else begin
      check("idle_width", stream_width, 0);
    end
    if (tok_valid) begin
      if (expt.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_token: type %0d, none expected", tok_type);
      end else begin
        t = expt[0];
        check("tok_type", tok_type, t.typ);
        if (t.typ == 2'b00) check("tok_lit", tok_lit, t.lit);
        if (t.typ == 2'b01) begin
          check("tok_off", tok_off, t.off);
          check("tok_len", tok_len, t.len);
        end
        check("tok_err", tok_err, 0);
        if (tok_ready) void'(expt.pop_front());
      end
    end
    @(posedge clk);
    #1;
    refresh();
  endtask

  task automatic run(input int unsigned max, output int unsigned used);
    used = 0;
    while ((expw.size() != 0 || expt.size() != 0) && used < max) begin
      cycle();
      used++;
    end
    if (expw.size() != 0 || expt.size() != 0) begin
      tests++; fails++;
      $display("FAIL timeout: %0d widths and %0d tokens outstanding", expw.size(), expt.size());
      expw.delete(); expt.delete(); bitq.delete();
      refresh();
    end
  endtask

  task automatic drive5(input logic [12:0] d, input logic [3:0] w);
    s5_data  = d;
    s5_valid = 1'b1;
    @(negedge clk);
    check("s5_ack", s5_ack, 1);
    check("s5_width", s5_width, w);
    @(posedge clk);
    #1;
    s5_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned used;

    vecs[0] = '{32'({1'b0, 8'h41}), 9, 2'b00, 8'h41, 11'd0, 11'd0, 24'h900000};
    vecs[1] = '{32'({2'b11, 7'd5, 2'b00}), 11, 2'b01, 8'h00, 11'd5, 11'd2, 24'h920000};
    vecs[2] = '{32'({2'b10, 11'd300, 4'hF, 4'hF, 4'h0}), 25, 2'b01, 8'h00, 11'd300, 11'd23, 24'hD44400};
    vecs[3] = '{32'({2'b11, 7'd127, 4'b1110}), 13, 2'b01, 8'h00, 11'd127, 11'd7, 24'h940000};
    vecs[4] = '{32'({1'b0, 8'hFF}), 9, 2'b00, 8'hFF, 11'd0, 11'd0, 24'h900000};
    vecs[5] = '{32'({2'b10, 11'd1, 2'b10}), 15, 2'b01, 8'h00, 11'd1, 11'd4, 24'hD20000};
    vecs[6] = '{32'({2'b11, 7'd1, 4'b1100}), 13, 2'b01, 8'h00, 11'd1, 11'd5, 24'h940000};
    vecs[7] = '{32'({2'b10, 11'd2047, 4'hF, 4'h3}), 21, 2'b01, 8'h00, 11'd2047, 11'd11, 24'hD44000};
    vecs[8] = '{32'({2'b11, 7'd64, 2'b01}), 11, 2'b01, 8'h00, 11'd64, 11'd3, 24'h920000};
    vecs[9] = '{32'({2'b10, 11'd1000, 4'hF, 4'hF, 4'hF, 4'h1}), 29, 2'b01, 8'h00, 11'd1000, 11'd39, 24'hD44440};

    rst = 1'b1; tok_ready = 1'b1; stream_done = 1'b0;
    s5_data = '0; s5_valid = 1'b0; s5_done = 1'b0; s5_ready = 1'b0;
    refresh();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tok_valid", tok_valid, 0);
    check("rst_tok_type", tok_type, 0);
    check("rst_tok_lit", tok_lit, 0);
    check("rst_tok_off", tok_off, 0);
    check("rst_tok_len", tok_len, 0);
    check("rst_tok_err", tok_err, 0);
    check("rst_ack", stream_ack, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    src_en = 1'b1;

    // Table of codes back-to-back, then an end marker with padding.
    for (int i = 0; i < 10; i++) push_vec(vecs[i]);
    push_end(1'b0);
    refresh();
    run(400, used);

    // Literal, end marker (pad 6), then a lone end marker: pad 7 shows bitcnt was cleared.
    push_vec(vecs[0]);
    push_end(1'b0);
    push_end(1'b0);
    refresh();
    run(100, used);

    // Same with stream_done: no padding ack, end token still emitted.
    stream_done = 1'b1;
    push_vec(vecs[0]);
    push_end(1'b1);
    refresh();
    run(100, used);
    stream_done = 1'b0;
    push_end(1'b0);
    refresh();
    run(100, used);

    // Literal throughput: four literals in eight cycles.
    for (int i = 0; i < 4; i++) push_vec(vecs[(i % 2 == 0) ? 0 : 4]);
    refresh();
    run(100, used);
    check("lit_throughput_cycles", used, 8);

    // stream_valid low mid-code: hold, no ack.
    push_vec(vecs[2]);
    refresh();
    cycle();
    cycle();
    src_en = 1'b0;
    refresh();
    repeat (3) cycle();
    src_en = 1'b1;
    refresh();
    run(100, used);

    // Backpressure: five stalled cycles with a further literal waiting.
    tok_ready = 1'b0;
    push_vec('{32'({1'b0, 8'h5A}), 9, 2'b00, 8'h5A, 11'd0, 11'd0, 24'h900000});
    push_vec('{32'({1'b0, 8'h33}), 9, 2'b00, 8'h33, 11'd0, 11'd0, 24'h900000});
    refresh();
    cycle();
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("stall_tok_valid", tok_valid, 1);
    end
    tok_ready = 1'b1;
    cycle();
    expect_idle = 1'b1;
    run(100, used);

    // Saturation on the LEN_W=5 instance: 8+15+15+15 -> 31, sticky error.
    drive5({2'b11, 7'd3, 4'd0}, 4'd9);
    drive5({4'hF, 9'd0}, 4'd4);
    drive5({4'hF, 9'd0}, 4'd4);
    drive5({4'hF, 9'd0}, 4'd4);
    drive5({4'hF, 9'd0}, 4'd4);
    drive5({4'h0, 9'd0}, 4'd4);
    @(negedge clk);
    check("sat_tok_valid", s5_tvalid, 1);
    check("sat_tok_type", s5_type, 2'b01);
    check("sat_tok_off", s5_off, 3);
    check("sat_tok_len", s5_len, 31);
    check("sat_tok_err", s5_err, 1);
    @(posedge clk);
    #1;
    s5_ready = 1'b1;
    @(posedge clk);
    #1;
    s5_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sat_valid_after_accept", s5_tvalid, 0);
    check("sat_err_sticky", s5_err, 1);

    // Reset in the middle of S_EXT discards the token and clears the error.
    @(posedge clk);
    #1;
    drive5({2'b11, 7'd9, 4'd0}, 4'd9);
    drive5({4'hF, 9'd0}, 4'd4);
    rst = 1'b1;
    #2;
    check("midrst_tok_valid", s5_tvalid, 0);
    check("midrst_tok_err", s5_err, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive5({1'b0, 8'h12, 4'd0}, 4'd9);
    @(negedge clk);
    check("post_rst_valid", s5_tvalid, 1);
    check("post_rst_type", s5_type, 2'b00);
    check("post_rst_lit", s5_lit, 8'h12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
